// File: rtl/counter_pkg.sv
// Shared types for the counter command sequencer.
// Command opcodes and sequencer states live here.
package counter_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_UP   = 2'b10,
    OP_DOWN = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COUNT
  } seq_state_e;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO holding {op,data} entries.
// Flush clears pointers and discards a same-edge push.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign do_push = push && (level != LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge Clk) begin
    if (do_push && !flush) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/counter_cmd_seq.sv
// Queues LOAD/UP/DOWN commands and plays them out as
// registered enable/load/direction strobes to a counter.
module counter_cmd_seq
  import counter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic                        Cmd_Valid,
  output logic                        Cmd_Ready,
  input  logic [1:0]                  Cmd_Op,
  input  logic [DATA_W-1:0]           Cmd_Data,
  input  logic                        Flush,
  output logic                        Enable_2,
  output logic                        Load_2,
  output logic                        UpDown_2,
  output logic [DATA_W-1:0]           In_Data_2,
  output logic                        Busy,
  output logic                        Done,
  output logic [$clog2(FIFO_DEPTH):0] Fifo_Level
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  seq_state_e        state;
  logic [DATA_W-1:0] rem;
  logic              rdy_q;
  logic              empty;
  logic              push;
  logic              pop;
  logic              last;
  logic              advance;
  logic [DATA_W+1:0] head;
  cmd_op_e           head_op;
  logic [DATA_W-1:0] head_data;
  logic              is_load;
  logic              is_run;

  // Ready is held low until the first edge after reset release.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) rdy_q <= 1'b0;
    else          rdy_q <= 1'b1;
  end

  assign Cmd_Ready = rdy_q && (Fifo_Level < LW'(FIFO_DEPTH));
  assign push      = Cmd_Valid && Cmd_Ready && !Flush;

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W + 2)
  ) u_fifo (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .flush   (Flush),
    .push    (push),
    .pop     (pop),
    .wdata   ({Cmd_Op, Cmd_Data}),
    .rdata   (head),
    .level   (Fifo_Level),
    .empty   (empty)
  );

  assign head_op   = cmd_op_e'(head[DATA_W+1:DATA_W]);
  assign head_data = head[DATA_W-1:0];
  assign is_load   = (head_op == OP_LOAD);
  assign is_run    = ((head_op == OP_UP) || (head_op == OP_DOWN))
                     && (head_data != '0);

  assign last    = (state == S_LOAD)
                   || ((state == S_COUNT) && (rem == '0));
  assign advance = (state == S_IDLE) || last;
  assign pop     = advance && !empty && !Flush;
  assign Busy    = (state != S_IDLE) || (Fifo_Level != '0);

  // rem counts the output cycles still owed after the current one.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= S_IDLE;
      rem       <= '0;
      Enable_2  <= 1'b0;
      Load_2    <= 1'b0;
      UpDown_2  <= 1'b0;
      In_Data_2 <= '0;
      Done      <= 1'b0;
    end else if (Flush) begin
      state    <= S_IDLE;
      Enable_2 <= 1'b0;
      Load_2   <= 1'b0;
      Done     <= 1'b0;
    end else if (advance) begin
      state    <= S_IDLE;
      Enable_2 <= 1'b0;
      Load_2   <= 1'b0;
      Done     <= 1'b0;
      if (!empty) begin
        unique case (1'b1)
          is_load: begin
            state     <= S_LOAD;
            Enable_2  <= 1'b1;
            Load_2    <= 1'b1;
            In_Data_2 <= head_data;
            Done      <= 1'b1;
          end
          is_run: begin
            state    <= S_COUNT;
            Enable_2 <= 1'b1;
            UpDown_2 <= (head_op == OP_UP);
            rem      <= head_data - 1'b1;
            Done     <= (head_data == DATA_W'(1));
          end
          default: Done <= 1'b1;
        endcase
      end
    end else begin
      rem  <= rem - 1'b1;
      Done <= (rem == DATA_W'(1));
    end
  end

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Directed bench for counter_cmd_seq with a behavioural
// downstream up/down counter fed by the sequencer strobes.
module tb_counter_cmd_seq;
  import counter_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Cmd_Valid = 1'b0;
  logic       Cmd_Ready;
  logic [1:0] Cmd_Op = 2'b00;
  logic [7:0] Cmd_Data = 8'h00;
  logic       Flush = 1'b0;
  logic       Enable_2;
  logic       Load_2;
  logic       UpDown_2;
  logic [7:0] In_Data_2;
  logic       Busy;
  logic       Done;
  logic [2:0] Fifo_Level;

  counter_cmd_seq #(
    .FIFO_DEPTH (4),
    .DATA_W     (8)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Cmd_Valid  (Cmd_Valid),
    .Cmd_Ready  (Cmd_Ready),
    .Cmd_Op     (Cmd_Op),
    .Cmd_Data   (Cmd_Data),
    .Flush      (Flush),
    .Enable_2   (Enable_2),
    .Load_2     (Load_2),
    .UpDown_2   (UpDown_2),
    .In_Data_2  (In_Data_2),
    .Busy       (Busy),
    .Done       (Done),
    .Fifo_Level (Fifo_Level)
  );

  always #5 Clk = ~Clk;

  // downstream counter model
  logic [7:0] cnt;
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)      cnt <= 8'h00;
    else if (Enable_2) cnt <= Load_2 ? In_Data_2
                            : (UpDown_2 ? cnt + 8'd1 : cnt - 8'd1);
  end

  int         en_cnt = 0;
  int         done_cnt = 0;
  int         max_lvl = 0;
  logic [9:0] trace[$];

  always @(negedge Clk) begin
    if (Enable_2) begin
      en_cnt++;
      trace.push_back({Load_2, Load_2 ? 1'b0 : UpDown_2, In_Data_2});
    end
    if (Done) done_cnt++;
    if (int'(Fifo_Level) > max_lvl) max_lvl = int'(Fifo_Level);
  end

  typedef struct {
    logic       v;
    logic [1:0] op;
    logic [7:0] d;
    logic       rdy, busy, en, ld, ud;
    logic [7:0] din;
    logic       dn;
    logic [2:0] lvl;
  } vec_t;

  vec_t       tbl[13];
  int         checks = 0;
  int         errors = 0;
  int         stalls, s, d0, e0, n;
  logic [9:0] expq[$];
  logic [16:0] got, want;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] op, input logic [7:0] d,
                      output int st);
    st = 0;
    Cmd_Valid = 1'b1;
    Cmd_Op = op;
    Cmd_Data = d;
    while (!Cmd_Ready && st < 300) begin
      @(posedge Clk);
      #1;
      st++;
    end
    if (!Cmd_Ready) chk("push_timeout", 32'd1, 32'd0);
    @(posedge Clk);
    #1;
    Cmd_Valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (Busy && k < 500) begin
      @(posedge Clk);
      #1;
      k++;
    end
    if (Busy) chk("idle_timeout", 32'd1, 32'd0);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    //          v  op  d      rdy busy en ld ud din    dn lvl
    tbl[0]  = '{1, 2'b01, 8'hA5, 1, 1, 0, 0, 0, 8'h00, 0, 3'd1};
    tbl[1]  = '{1, 2'b10, 8'h03, 1, 1, 1, 1, 0, 8'hA5, 1, 3'd1};
    tbl[2]  = '{0, 2'b00, 8'h00, 1, 1, 1, 0, 1, 8'hA5, 0, 3'd0};
    tbl[3]  = '{0, 2'b00, 8'h00, 1, 1, 1, 0, 1, 8'hA5, 0, 3'd0};
    tbl[4]  = '{0, 2'b00, 8'h00, 1, 1, 1, 0, 1, 8'hA5, 1, 3'd0};
    tbl[5]  = '{0, 2'b00, 8'h00, 1, 0, 0, 0, 1, 8'hA5, 0, 3'd0};
    tbl[6]  = '{1, 2'b11, 8'h00, 1, 1, 0, 0, 1, 8'hA5, 0, 3'd1};
    tbl[7]  = '{1, 2'b00, 8'h00, 1, 1, 0, 0, 1, 8'hA5, 1, 3'd1};
    tbl[8]  = '{0, 2'b00, 8'h00, 1, 0, 0, 0, 1, 8'hA5, 1, 3'd0};
    tbl[9]  = '{0, 2'b00, 8'h00, 1, 0, 0, 0, 1, 8'hA5, 0, 3'd0};
    tbl[10] = '{1, 2'b11, 8'h01, 1, 1, 0, 0, 1, 8'hA5, 0, 3'd1};
    tbl[11] = '{0, 2'b00, 8'h00, 1, 1, 1, 0, 0, 8'hA5, 1, 3'd0};
    tbl[12] = '{0, 2'b00, 8'h00, 1, 0, 0, 0, 0, 8'hA5, 0, 3'd0};

    // reset state
    #1;
    got = {Cmd_Ready, Busy, Enable_2, Load_2, UpDown_2,
           In_Data_2, Done, Fifo_Level};
    chk("reset_outputs", 32'(got), 32'd0);
    #11;
    Reset_n = 1'b1;
    #1;
    chk("ready_before_edge", 32'(Cmd_Ready), 32'd0);
    @(posedge Clk);
    #1;
    chk("ready_after_release", 32'(Cmd_Ready), 32'd1);

    // LOAD A5 / UP 3 / DOWN 0 / NOP / DOWN 1, cycle by cycle
    for (int i = 0; i < 13; i++) begin
      Cmd_Valid = tbl[i].v;
      Cmd_Op = tbl[i].op;
      Cmd_Data = tbl[i].d;
      @(posedge Clk);
      #1;
      got = {Cmd_Ready, Busy, Enable_2, Load_2, UpDown_2,
             In_Data_2, Done, Fifo_Level};
      want = {tbl[i].rdy, tbl[i].busy, tbl[i].en, tbl[i].ld,
              tbl[i].ud, tbl[i].din, tbl[i].dn, tbl[i].lvl};
      chk($sformatf("vec%0d", i), 32'(got), 32'(want));
    end
    Cmd_Valid = 1'b0;
    chk("cnt_after_table", 32'(cnt), 32'hA7);

    // fill: five pushes behind a long UP, fifth must stall
    s = trace.size();
    d0 = done_cnt;
    push(2'b10, 8'd8, stalls);
    push(2'b01, 8'h11, stalls);
    push(2'b10, 8'd2, stalls);
    push(2'b11, 8'd1, stalls);
    push(2'b01, 8'h33, stalls);
    push(2'b10, 8'd1, stalls);
    chk("fill_stalled", 32'(stalls > 0), 32'd1);
    wait_idle();
    chk("fill_max_level", 32'(max_lvl), 32'd4);
    chk("fill_done_count", 32'(done_cnt - d0), 32'd6);
    for (int i = 0; i < 8; i++) expq.push_back({2'b01, 8'hA5});
    expq.push_back({2'b10, 8'h11});
    expq.push_back({2'b01, 8'h11});
    expq.push_back({2'b01, 8'h11});
    expq.push_back({2'b00, 8'h11});
    expq.push_back({2'b10, 8'h33});
    expq.push_back({2'b01, 8'h33});
    chk("fill_trace_len", 32'(trace.size() - s), 32'(expq.size()));
    for (int i = 0; i < expq.size(); i++) begin
      if (s + i < trace.size())
        chk($sformatf("fill_trace%0d", i), 32'(trace[s + i]),
            32'(expq[i]));
    end
    chk("cnt_after_fill", 32'(cnt), 32'h34);

    // chained counter: wrap up and down
    push(2'b01, 8'hFE, stalls);
    push(2'b10, 8'd3, stalls);
    wait_idle();
    chk("cnt_wrap_up", 32'(cnt), 32'h01);
    push(2'b11, 8'd2, stalls);
    wait_idle();
    chk("cnt_wrap_down", 32'(cnt), 32'hFF);

    // flush during UP 200 with two queued
    d0 = done_cnt;
    e0 = en_cnt;
    push(2'b10, 8'd200, stalls);
    push(2'b01, 8'h05, stalls);
    push(2'b00, 8'h00, stalls);
    n = 0;
    while ((en_cnt - e0) < 10 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    chk("flush_reached_cycle10", 32'(en_cnt - e0), 32'd10);
    chk("flush_level_before", 32'(Fifo_Level), 32'd2);
    Flush = 1'b1;
    Cmd_Valid = 1'b1;
    Cmd_Op = 2'b01;
    Cmd_Data = 8'h77;
    @(posedge Clk);
    #1;
    Flush = 1'b0;
    Cmd_Valid = 1'b0;
    chk("flush_enable", 32'(Enable_2), 32'd0);
    chk("flush_level", 32'(Fifo_Level), 32'd0);
    chk("flush_done", 32'(Done), 32'd0);
    chk("flush_busy", 32'(Busy), 32'd0);
    e0 = en_cnt;
    repeat (5) @(posedge Clk);
    #1;
    chk("flush_no_done", 32'(done_cnt - d0), 32'd0);
    chk("flush_no_enable", 32'(en_cnt - e0), 32'd0);

    // asynchronous reset mid-COUNT
    push(2'b10, 8'd50, stalls);
    push(2'b01, 8'h09, stalls);
    repeat (3) @(posedge Clk);
    #3;
    d0 = done_cnt;
    chk("rst_pre_enable", 32'(Enable_2), 32'd1);
    Reset_n = 1'b0;
    #1;
    got = {Cmd_Ready, Busy, Enable_2, Load_2, UpDown_2,
           In_Data_2, Done, Fifo_Level};
    chk("rst_async_outputs", 32'(got), 32'd0);
    repeat (2) @(posedge Clk);
    #2;
    Reset_n = 1'b1;
    #1;
    chk("rst_ready_low", 32'(Cmd_Ready), 32'd0);
    @(posedge Clk);
    #1;
    chk("rst_ready_high", 32'(Cmd_Ready), 32'd1);
    e0 = en_cnt;
    repeat (5) @(posedge Clk);
    #1;
    chk("rst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("rst_no_enable", 32'(en_cnt - e0), 32'd0);
    chk("rst_level", 32'(Fifo_Level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
